pwm_timebase_ctrl: RTL

PWM_TIMEBASE_CTRL -- requirements
Module: pwm_timebase_ctrl

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_timebase_ctrl_if.sv | 34 +++
 rtl/pwm_timebase_next.sv | 60 ++++++
 rtl/pwm_timebase_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM timebase: counter width, counting modes
// and the controller state encoding.
package pwm_pkg;

    localparam int unsigned CNT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [1:0]       mode_t;

    // 2'b11 is not a mode of its own; the next-value logic counts it as up
    localparam mode_t MODE_UP     = 2'b00;
    localparam mode_t MODE_DOWN   = 2'b01;
    localparam mode_t MODE_UPDOWN = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_timebase_ctrl_if.sv
// Control/status bundle of the PWM timebase; the master drives the controls,
// the slave (the timebase itself) drives the count and status outputs.
interface pwm_timebase_ctrl_if;
    import pwm_pkg::*;

    logic  i_start;
    logic  i_stop;
    logic  i_oneshot;
    mode_t i_mode;
    cnt_t  i_period;
    logic  i_sync;
    cnt_t  i_phase;

    cnt_t  o_counter;
    cnt_t  o_counter_next;
    logic  o_dir;
    logic  o_zero;
    logic  o_period_match;
    logic  o_running;
    logic  o_done;

    modport master (
        output i_start, i_stop, i_oneshot, i_mode, i_period, i_sync, i_phase,
        input  o_counter, o_counter_next, o_dir, o_zero, o_period_match,
               o_running, o_done
    );

    modport slave (
        input  i_start, i_stop, i_oneshot, i_mode, i_period, i_sync, i_phase,
        output o_counter, o_counter_next, o_dir, o_zero, o_period_match,
               o_running, o_done
    );

endinterface

// File: rtl/pwm_timebase_next.sv
// Combinational next-count / next-direction logic for one counting step,
// including the phase reload and the period-end flag.
module pwm_timebase_next
    import pwm_pkg::*;
(
    input  cnt_t  counter,
    input  logic  dir,
    input  mode_t mode,
    input  cnt_t  period,
    input  logic  sync,
    input  cnt_t  phase,
    output cnt_t  next_count,
    output logic  next_dir,
    output logic  period_end
);

    always_comb begin
        next_count = counter;
        next_dir   = dir;
        period_end = 1'b0;
        case (mode)
            MODE_DOWN: begin
                period_end = (counter == '0);
                next_dir   = 1'b1;
                next_count = period_end ? period : counter - 1'b1;
            end
            MODE_UPDOWN: begin
                // a zero period pins the count at 0 and makes every cycle a period end
                period_end = (dir && (counter == '0)) || (period == '0);
                if (period == '0) begin
                    next_count = '0;
                    next_dir   = dir ? (counter != '0) : 1'b1;
                end else if (!dir) begin
                    if (counter >= period) begin
                        next_dir   = 1'b1;
                        next_count = counter - 1'b1;
                    end else begin
                        next_count = counter + 1'b1;
                    end
                end else if (counter == '0) begin
                    next_dir   = 1'b0;
                    next_count = cnt_t'(1);
                end else begin
                    next_count = counter - 1'b1;
                end
            end
            default: begin
                period_end = (counter >= period);
                next_dir   = 1'b0;
                next_count = period_end ? '0 : counter + 1'b1;
            end
        endcase

        if (sync) begin
            next_count = (phase < period) ? phase : period;
            next_dir   = 1'b0;
        end
    end

endmodule

// File: rtl/pwm_timebase_ctrl.sv
// PWM timebase controller: IDLE/RUN/STOPPING sequencing around a 16-bit
// up/down/up-down counter with live period, phase sync and one-shot support.
module pwm_timebase_ctrl
    import pwm_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    pwm_timebase_ctrl_if.slave   bus
);

    state_t state, state_nx;
    cnt_t   counter, counter_nx, calc_count;
    logic   dir, dir_nx, calc_dir;
    logic   done;
    mode_t  mode_q;
    logic   oneshot_q;
    logic   active, sync_run, period_end, stop_exit;

    assign active   = (state != IDLE);
    assign sync_run = active && bus.i_sync;
    // a sync in the period-end cycle cancels a pending stop until the next period end
    assign stop_exit = active && period_end && !bus.i_sync
                       && ((state == STOPPING) || oneshot_q);

    pwm_timebase_next u_next (
        .counter    (counter),
        .dir        (dir),
        .mode       (mode_q),
        .period     (bus.i_period),
        .sync       (sync_run),
        .phase      (bus.i_phase),
        .next_count (calc_count),
        .next_dir   (calc_dir),
        .period_end (period_end)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (bus.i_start) state_nx = RUN;
            RUN:      if (stop_exit) state_nx = IDLE;
                      else if (bus.i_stop) state_nx = STOPPING;
            STOPPING: if (stop_exit) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        counter_nx = counter;
        dir_nx     = dir;
        if (!active) begin
            if (bus.i_start) begin
                counter_nx = (bus.i_mode == MODE_DOWN) ? bus.i_period : '0;
                dir_nx     = (bus.i_mode == MODE_DOWN);
            end
        end else if (stop_exit) begin
            counter_nx = '0;
            dir_nx     = 1'b0;
        end else begin
            counter_nx = calc_count;
            dir_nx     = calc_dir;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            counter   <= '0;
            dir       <= 1'b0;
            done      <= 1'b0;
            mode_q    <= MODE_UP;
            oneshot_q <= 1'b0;
        end else begin
            counter <= counter_nx;
            dir     <= dir_nx;
            done    <= stop_exit;
            if (!active && bus.i_start) begin
                mode_q    <= bus.i_mode;
                oneshot_q <= bus.i_oneshot;
            end
        end
    end

    always_comb begin
        bus.o_counter      = counter;
        bus.o_counter_next = counter_nx;
        bus.o_dir          = dir;
        bus.o_zero         = active && (counter == '0);
        bus.o_period_match = active && (counter == bus.i_period);
        bus.o_running      = active;
        bus.o_done         = done;
    end

endmodule
